// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package niosii_system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID_REQ,
    ST_RD_ID_WAIT,
    ST_RD_TS_REQ,
    ST_RD_TS_WAIT,
    ST_DONE
  } sysid_chk_state_t;

  localparam logic [1:0] SYSID_ERR_OK  = 2'd0;
  localparam logic [1:0] SYSID_ERR_ID  = 2'd1;
  localparam logic [1:0] SYSID_ERR_TS  = 2'd2;
  localparam logic [1:0] SYSID_ERR_TMO = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  function automatic logic is_req_state(sysid_chk_state_t s);
    return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
  endfunction

  function automatic logic is_wait_state(sysid_chk_state_t s);
    return (s == ST_RD_ID_WAIT) || (s == ST_RD_TS_WAIT);
  endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface niosii_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/niosii_system_sysid_checker_timeout.sv
// Per-read cycle counter; expired_o flags the last allowed cycle of a read.
module niosii_system_sysid_checker_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled FSM never wraps back to a fresh budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);
endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Boot-time sequencer: reads sysid ID and timestamp words, compares, reports.
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1489180159,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o,
  niosii_system_sysid_checker_if.master avm
);
  localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRIES);

  sysid_chk_state_t state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic        stale_q, stale_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic tmo_clear, tmo_enable, tmo_expired, tmo_fire, rdv_ok;

  assign tmo_enable = is_req_state(state_q) || is_wait_state(state_q);
  assign rdv_ok     = avm.avm_readdatavalid && !stale_q;

  niosii_system_sysid_checker_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    stale_d   = stale_q;
    pass_d    = pass_q;
    err_d     = err_q;
    id_d      = id_q;
    ts_d      = ts_q;
    tmo_clear = 1'b0;
    tmo_fire  = 1'b0;

    // Any response arriving while a stale one is owed is that stale one.
    if (avm.avm_readdatavalid && stale_q) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RD_ID_REQ;
          tmo_clear = 1'b1;
          retry_d   = '0;
          pass_d    = 1'b0;
          err_d     = SYSID_ERR_OK;
        end
      end
      ST_RD_ID_REQ, ST_RD_TS_REQ: begin
        if (tmo_expired) begin
          tmo_fire = 1'b1;
          // Accepted on the very cycle we give up: its response will still come.
          if (!avm.avm_waitrequest) begin
            stale_d = 1'b1;
          end
        end else if (!avm.avm_waitrequest) begin
          state_d = (state_q == ST_RD_ID_REQ) ? ST_RD_ID_WAIT : ST_RD_TS_WAIT;
        end
      end
      ST_RD_ID_WAIT: begin
        if (rdv_ok) begin
          id_d = avm.avm_readdata;
          if (avm.avm_readdata != EXP_ID) begin
            state_d = ST_DONE;
            err_d   = SYSID_ERR_ID;
          end else begin
            state_d   = ST_RD_TS_REQ;
            tmo_clear = 1'b1;
          end
        end else if (tmo_expired) begin
          tmo_fire = 1'b1;
          stale_d  = 1'b1;
        end
      end
      ST_RD_TS_WAIT: begin
        if (rdv_ok) begin
          ts_d    = avm.avm_readdata;
          state_d = ST_DONE;
          if (avm.avm_readdata != EXP_TIMESTAMP) begin
            err_d = SYSID_ERR_TS;
          end else begin
            err_d  = SYSID_ERR_OK;
            pass_d = 1'b1;
          end
        end else if (tmo_expired) begin
          tmo_fire = 1'b1;
          stale_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tmo_fire) begin
      if (retry_q < MAX_RETRY_CNT) begin
        retry_d   = retry_q + 4'd1;
        state_d   = ST_RD_ID_REQ;
        tmo_clear = 1'b1;
      end else begin
        state_d = ST_DONE;
        err_d   = SYSID_ERR_TMO;
        pass_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      stale_q <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= SYSID_ERR_OK;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      stale_q <= stale_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign pass_o          = pass_q;
  assign err_code_o      = err_q;
  assign id_value_o      = id_q;
  assign ts_value_o      = ts_q;
  assign avm.avm_read    = is_req_state(state_q);
  assign avm.avm_address = (state_q == ST_RD_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Scoreboard bench: directed runs against a behavioural in-order Avalon slave.
module tb_niosii_system_sysid_checker;
  import niosii_system_sysid_checker_pkg::*;

  localparam int          TMO     = 16;
  localparam logic [31:0] GOOD_ID = 32'h0000_0000;
  localparam logic [31:0] GOOD_TS = 32'd1489180159;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  err;
  logic [31:0] id_v, ts_v;

  niosii_system_sysid_checker_if bus();

  niosii_system_sysid_checker #(
    .EXP_ID        (GOOD_ID),
    .EXP_TIMESTAMP (GOOD_TS),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
    .err_code_o(err),
    .id_value_o(id_v),
    .ts_value_o(ts_v),
    .avm       (bus.master)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          done_cyc;
    int          reads;
    int          reads_a1;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  exp_t  exp_q[$];
  string name_q[$];
  rsp_t  rsp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, reads = 0, reads_a1 = 0;
  int done_seen = 0, done_exp = 0, stall_viol = 0;

  // slave configuration
  int          stall_cycles = 0;
  int          lat = 1;
  int          delay_first = 0;
  bit          no_resp = 1'b0;
  logic [31:0] id_data = GOOD_ID;
  logic [31:0] ts_data = GOOD_TS;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural in-order slave, updated 1 time unit after each edge.
  initial begin : slave
    rsp_t r;
    bit   req_active;
    int   stall_left;
    bit   wr, prev_wr;
    logic prev_addr;
    req_active = 1'b0; stall_left = 0; wr = 1'b0; prev_wr = 1'b0; prev_addr = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rsp_q.delete();
        req_active = 1'b0;
        prev_wr = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = r.data;
        end else begin
          bus.avm_readdatavalid = 1'b0;
          bus.avm_readdata = 32'h0;
        end
        if (prev_wr && (!bus.avm_read || bus.avm_address != prev_addr)) stall_viol++;
        wr = 1'b0;
        if (bus.avm_read) begin
          if (!req_active) begin
            req_active = 1'b1;
            stall_left = stall_cycles;
          end
          if (stall_left > 0) begin
            wr = 1'b1;
            stall_left--;
          end else begin
            req_active = 1'b0;
            if (!no_resp) begin
              r.data = bus.avm_address ? ts_data : id_data;
              r.due  = cyc + lat;
              if (delay_first > 0) begin
                r.due  = cyc + delay_first;
                r.data = 32'hBAD0_0001;
                delay_first = 0;
              end
              if (rsp_q.size() > 0 && r.due <= rsp_q[$].due) r.due = rsp_q[$].due + 1;
              rsp_q.push_back(r);
            end
          end
        end else begin
          req_active = 1'b0;
        end
        bus.avm_waitrequest = wr;
        prev_wr = wr;
        prev_addr = bus.avm_address;
      end
    end
  end

  // Monitor: counts accepted reads and scores every done pulse.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (!rst && bus.avm_read && !bus.avm_waitrequest) begin
        reads++;
        if (bus.avm_address) reads_a1++;
      end
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, ".done_cycle"}, cyc, e.done_cyc);
          check({nm, ".pass"}, {31'h0, pass}, {31'h0, e.pass});
          check({nm, ".err_code"}, {30'h0, err}, {30'h0, e.err});
          check({nm, ".id_value"}, id_v, e.id);
          check({nm, ".ts_value"}, ts_v, e.ts);
          check({nm, ".reads"}, reads, e.reads);
          check({nm, ".reads_addr1"}, reads_a1, e.reads_a1);
          $display("txn %s: done@%0d pass=%0d err=%0d id=%h ts=%h reads=%0d",
                   nm, cyc, pass, err, id_v, ts_v, reads);
        end
      end
    end
  end

  task automatic run(input string nm, input int done_rel, input logic p, input logic [1:0] e,
                     input logic [31:0] idv, input logic [31:0] tsv, input int nr, input int nr1);
    exp_t x;
    @(posedge clk);
    #2;
    reads = 0;
    reads_a1 = 0;
    x.pass = p; x.err = e; x.id = idv; x.ts = tsv;
    x.done_cyc = cyc + done_rel; x.reads = nr; x.reads_a1 = nr1;
    exp_q.push_back(x);
    name_q.push_back(nm);
    done_exp++;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got no done after %0d cycles expected %0d pending done", budget, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, ".busy"}, {31'h0, busy}, 32'h0);
    check({pfx, ".done"}, {31'h0, done}, 32'h0);
    check({pfx, ".pass"}, {31'h0, pass}, 32'h0);
    check({pfx, ".err_code"}, {30'h0, err}, 32'h0);
    check({pfx, ".id_value"}, id_v, 32'h0);
    check({pfx, ".ts_value"}, ts_v, 32'h0);
    check({pfx, ".avm_read"}, {31'h0, bus.avm_read}, 32'h0);
    check({pfx, ".avm_address"}, {31'h0, bus.avm_address}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    // Zero-wait slave: 1 REQ + 1 WAIT per word, done 5 cycles after start sampled.
    run("zero_wait", 5, 1'b1, SYSID_ERR_OK, GOOD_ID, GOOD_TS, 2, 1);
    wait_done(40);
    repeat (3) @(negedge clk);
    check("zero_wait.pass_held", {31'h0, pass}, 32'h1);

    do_reset();
    id_data = 32'h0000_0001;
    run("id_mismatch", 3, 1'b0, SYSID_ERR_ID, 32'h1, 32'h0, 1, 0);
    wait_done(40);

    do_reset();
    id_data = GOOD_ID;
    ts_data = 32'h5555_AAAA;
    run("ts_mismatch", 5, 1'b0, SYSID_ERR_TS, GOOD_ID, 32'h5555_AAAA, 2, 1);
    wait_done(40);

    // 10 stalled REQ cycles + accept cycle + 3 WAIT cycles per word: 1+14+14 -> done at 29.
    do_reset();
    ts_data = GOOD_TS;
    stall_cycles = 10;
    lat = 3;
    stall_viol = 0;
    run("stall", 29, 1'b1, SYSID_ERR_OK, GOOD_ID, GOOD_TS, 2, 1);
    wait_done(100);
    check("stall.addr_read_stable", stall_viol, 0);

    // Reads accepted but never answered: 4 attempts of TMO cycles each, done at 4*16+1.
    do_reset();
    stall_cycles = 0;
    lat = 1;
    no_resp = 1'b1;
    run("timeout", 4 * TMO + 1, 1'b0, SYSID_ERR_TMO, 32'h0, 32'h0, 4, 0);
    wait_done(200);

    // First ID response (bad data) arrives at cycle 19, after the timeout at 16;
    // retry read accepted at 17 is answered at 20, TS read at 21/22, done at 23.
    do_reset();
    no_resp = 1'b0;
    delay_first = 18;
    run("stale", 23, 1'b1, SYSID_ERR_OK, GOOD_ID, GOOD_TS, 3, 1);
    wait_done(100);

    // Reset while the TS response is outstanding (lat 5: TS_WAIT spans cycles 8..12).
    do_reset();
    lat = 5;
    @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ts_wait.busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    lat = 1;
    @(negedge clk);
    check_reset_outputs("rst_in_ts_wait");
    @(posedge clk);
    run("after_reset", 5, 1'b1, SYSID_ERR_OK, GOOD_ID, GOOD_TS, 2, 1);
    @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(40);
    repeat (15) @(negedge clk);
    check("done_pulse_count", done_seen, done_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
